// File: rtl/ps2_key_controller.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_controller
//  Purpose  : System-clocked PS/2 keyboard receiver for the game input path.
//             Synchronises and filters PS2_CLK/PS2_DAT, receives 11-bit frames
//             (start, 8 data LSB first, odd parity, stop) with error and
//             timeout recovery, tracks make/break state of A, D and Enter and
//             arbitrates left/right movement.
//  Ports    : CLOCK_50    in   system clock (rising edge)
//             resetn      in   asynchronous active-low reset
//             PS2_CLK     in   raw PS/2 clock
//             PS2_DAT     in   raw PS/2 data
//             code        out  [7:0] last good received byte
//             code_valid  out  1-cycle pulse, good frame received
//             frame_err   out  1-cycle pulse, parity/stop/timeout error
//             A, D, Enter out  key held flags (1C, 23, 5A)
//             move        out  [1:0] 00 none, 10 left (A), 01 right (D)
//             start_pulse out  1-cycle pulse on fresh Enter make
//             signal      out  [2:0] last make: 100 A, 001 D, 111 Enter, 000 other
//  Revision : 1.0  initial release
// ============================================================================
module ps2_key_controller #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err,
  output logic       A,
  output logic       D,
  output logic       Enter,
  output logic [1:0] move,
  output logic       start_pulse,
  output logic [2:0] signal
);

  localparam int c_FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int c_TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_FCNT_W-1:0] c_FCNT_MAX = c_FCNT_W'(FILTER_LEN - 1);
  localparam logic [c_TO_W-1:0]   c_TO_MAX   = c_TO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_DATA   = 2'd1;
  localparam logic [1:0] c_PARITY = 2'd2;
  localparam logic [1:0] c_STOP   = 2'd3;

  localparam logic [7:0] c_KEY_A     = 8'h1C;
  localparam logic [7:0] c_KEY_D     = 8'h23;
  localparam logic [7:0] c_KEY_ENTER = 8'h5A;
  localparam logic [7:0] c_PFX_BRK   = 8'hF0;
  localparam logic [7:0] c_PFX_EXT   = 8'hE0;

  // --------------------------------------------------------------------------
  // Input synchronisers. Reset to 1 so an idle bus does not look like a
  // falling edge right after reset release.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   w_clk_s;
  logic                   w_dat_s;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], PS2_DAT};
    end
  end

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Clock filter: the counter tracks how long the synced clock has disagreed
  // with the filtered value; the filtered clock follows only once FILTER_LEN
  // consecutive disagreeing samples have been seen.
  // --------------------------------------------------------------------------
  logic                r_filt_clk;
  logic [c_FCNT_W-1:0] r_filt_cnt;
  logic                w_flip;
  logic                w_fall;

  assign w_flip = (w_clk_s != r_filt_clk) && (r_filt_cnt == c_FCNT_MAX);
  assign w_fall = w_flip && r_filt_clk;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
    end else if (w_clk_s == r_filt_clk) begin
      r_filt_cnt <= '0;
    end else if (w_flip) begin
      r_filt_clk <= w_clk_s;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + c_FCNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Frame receiver
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_par_ok;
  logic [c_TO_W-1:0] r_to_cnt;
  logic [7:0]        r_code;
  logic              r_code_valid;
  logic              r_frame_err;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state      <= c_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_ok     <= 1'b0;
      r_to_cnt     <= '0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_state == c_IDLE) begin
        r_to_cnt <= '0;
        // A high sample here is a glitch, not a start bit.
        if (w_fall && !w_dat_s) begin
          r_state   <= c_DATA;
          r_bit_cnt <= '0;
        end
      end else if (w_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          c_DATA: begin
            r_shift   <= {w_dat_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= c_PARITY;
            end
          end
          c_PARITY: begin
            // Odd parity: ones across data and parity bit must be odd.
            r_par_ok <= (^r_shift) ^ w_dat_s;
            r_state  <= c_STOP;
          end
          default: begin
            if (w_dat_s && r_par_ok) begin
              r_code       <= r_shift;
              r_code_valid <= 1'b1;
            end else begin
              r_frame_err  <= 1'b1;
            end
            r_state <= c_IDLE;
          end
        endcase
      end else if (r_to_cnt == c_TO_MAX) begin
        r_frame_err <= 1'b1;
        r_to_cnt    <= '0;
        r_state     <= c_IDLE;
      end else begin
        r_to_cnt <= r_to_cnt + c_TO_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Prefix tracking and key decode, one cycle after code_valid.
  // r_last_d records which key won the most recent fresh make (1 = D), used
  // only while both movement keys are held.
  // --------------------------------------------------------------------------
  logic       r_brk;
  logic       r_ext;
  logic       r_key_a;
  logic       r_key_d;
  logic       r_key_enter;
  logic       r_last_d;
  logic [2:0] r_signal;
  logic       r_start;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_brk       <= 1'b0;
      r_ext       <= 1'b0;
      r_key_a     <= 1'b0;
      r_key_d     <= 1'b0;
      r_key_enter <= 1'b0;
      r_last_d    <= 1'b0;
      r_signal    <= 3'b000;
      r_start     <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (r_frame_err) begin
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end else if (r_code_valid) begin
        if (r_code == c_PFX_BRK) begin
          r_brk <= 1'b1;
        end else if (r_code == c_PFX_EXT) begin
          r_ext <= 1'b1;
        end else begin
          r_brk <= 1'b0;
          r_ext <= 1'b0;
          if (!r_ext && !r_brk) begin
            case (r_code)
              c_KEY_A: begin
                r_key_a  <= 1'b1;
                r_signal <= 3'b100;
                // Typematic repeat of a held key keeps the current winner.
                if (!r_key_a) r_last_d <= 1'b0;
              end
              c_KEY_D: begin
                r_key_d  <= 1'b1;
                r_signal <= 3'b001;
                if (!r_key_d) r_last_d <= 1'b1;
              end
              c_KEY_ENTER: begin
                r_key_enter <= 1'b1;
                r_signal    <= 3'b111;
                if (!r_key_enter) r_start <= 1'b1;
              end
              default: r_signal <= 3'b000;
            endcase
          end else if (!r_ext) begin
            case (r_code)
              c_KEY_A:     r_key_a     <= 1'b0;
              c_KEY_D:     r_key_d     <= 1'b0;
              c_KEY_ENTER: r_key_enter <= 1'b0;
              default:     ;
            endcase
          end
        end
      end
    end
  end

  // Releasing the winner hands control to the other key automatically.
  logic [1:0] w_move;
  always_comb begin
    w_move = 2'b00;
    if (r_key_a && r_key_d) begin
      w_move = r_last_d ? 2'b01 : 2'b10;
    end else if (r_key_a) begin
      w_move = 2'b10;
    end else if (r_key_d) begin
      w_move = 2'b01;
    end
  end

  assign code        = r_code;
  assign code_valid  = r_code_valid;
  assign frame_err   = r_frame_err;
  assign A           = r_key_a;
  assign D           = r_key_d;
  assign Enter       = r_key_enter;
  assign move        = w_move;
  assign start_pulse = r_start;
  assign signal      = r_signal;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_controller
//  Purpose  : Self-checking bench for ps2_key_controller. A vector table of
//             frames with expected outputs, plus hand sequences for timeout,
//             clock glitch and mid-frame reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_key_controller;

  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 600;
  localparam int HALF        = 20;
  localparam int NV          = 25;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;
  logic       key_a;
  logic       key_d;
  logic       key_enter;
  logic [1:0] move;
  logic       start_pulse;
  logic [2:0] signal;

  ps2_key_controller #(
    .SYNC_STAGES(2),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLOCK_50   (clk),
    .resetn     (rst_n),
    .PS2_CLK    (ps2_clk),
    .PS2_DAT    (ps2_dat),
    .code       (code),
    .code_valid (code_valid),
    .frame_err  (frame_err),
    .A          (key_a),
    .D          (key_d),
    .Enter      (key_enter),
    .move       (move),
    .start_pulse(start_pulse),
    .signal     (signal)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Monotonic pulse counters; tests take deltas.
  int n_cv = 0;
  int n_fe = 0;
  int n_sp = 0;
  always @(posedge clk) begin
    if (code_valid)  n_cv = n_cv + 1;
    if (frame_err)   n_fe = n_fe + 1;
    if (start_pulse) n_sp = n_sp + 1;
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       stop;
    logic [7:0] e_code;
    int         e_cv;
    int         e_fe;
    int         e_sp;
    logic       e_a;
    logic       e_d;
    logic       e_en;
    logic [1:0] e_mv;
    logic [2:0] e_sig;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mk(input logic [7:0] data, input logic bp, input logic st,
                              input logic [7:0] c, input int cv, input int fe, input int sp,
                              input logic a, input logic d, input logic en,
                              input logic [1:0] mv, input logic [2:0] sig);
    vec_t v;
    v.data = data; v.bad_par = bp; v.stop = st; v.e_code = c;
    v.e_cv = cv; v.e_fe = fe; v.e_sp = sp;
    v.e_a = a; v.e_d = d; v.e_en = en; v.e_mv = mv; v.e_sig = sig;
    return v;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_dat = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i]);
    ps2_dat = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic chk_keys(input string tag, input logic a, input logic d, input logic en,
                          input logic [1:0] mv, input logic [2:0] sig, input logic [7:0] c);
    chk({tag, "_A"}, 32'(key_a), 32'(a));
    chk({tag, "_D"}, 32'(key_d), 32'(d));
    chk({tag, "_Enter"}, 32'(key_enter), 32'(en));
    chk({tag, "_move"}, 32'(move), 32'(mv));
    chk({tag, "_signal"}, 32'(signal), 32'(sig));
    chk({tag, "_code"}, 32'(code), 32'(c));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_cv;
    int b_fe;
    int b_sp;
    int waited;

    //            data  bp    st    code  cv fe sp A     D     En    move   sig
    vecs[0]  = mk(8'h1C, 1'b0, 1'b1, 8'h1C, 1, 0, 0, 1'b1, 1'b0, 1'b0, 2'b10, 3'b100);
    vecs[1]  = mk(8'hF0, 1'b0, 1'b1, 8'hF0, 1, 0, 0, 1'b1, 1'b0, 1'b0, 2'b10, 3'b100);
    vecs[2]  = mk(8'h1C, 1'b0, 1'b1, 8'h1C, 1, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b100);
    vecs[3]  = mk(8'h1C, 1'b0, 1'b1, 8'h1C, 1, 0, 0, 1'b1, 1'b0, 1'b0, 2'b10, 3'b100);
    vecs[4]  = mk(8'h23, 1'b0, 1'b1, 8'h23, 1, 0, 0, 1'b1, 1'b1, 1'b0, 2'b01, 3'b001);
    vecs[5]  = mk(8'hF0, 1'b0, 1'b1, 8'hF0, 1, 0, 0, 1'b1, 1'b1, 1'b0, 2'b01, 3'b001);
    vecs[6]  = mk(8'h23, 1'b0, 1'b1, 8'h23, 1, 0, 0, 1'b1, 1'b0, 1'b0, 2'b10, 3'b001);
    vecs[7]  = mk(8'hF0, 1'b0, 1'b1, 8'hF0, 1, 0, 0, 1'b1, 1'b0, 1'b0, 2'b10, 3'b001);
    vecs[8]  = mk(8'h1C, 1'b0, 1'b1, 8'h1C, 1, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b001);
    vecs[9]  = mk(8'h5A, 1'b0, 1'b1, 8'h5A, 1, 0, 1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b111);
    vecs[10] = mk(8'h5A, 1'b0, 1'b1, 8'h5A, 1, 0, 0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b111);
    vecs[11] = mk(8'hF0, 1'b0, 1'b1, 8'hF0, 1, 0, 0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b111);
    vecs[12] = mk(8'h5A, 1'b0, 1'b1, 8'h5A, 1, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b111);
    vecs[13] = mk(8'h1C, 1'b1, 1'b1, 8'h5A, 0, 1, 0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b111);
    vecs[14] = mk(8'h23, 1'b0, 1'b0, 8'h5A, 0, 1, 0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b111);
    vecs[15] = mk(8'hE0, 1'b0, 1'b1, 8'hE0, 1, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b111);
    vecs[16] = mk(8'h1C, 1'b0, 1'b1, 8'h1C, 1, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b111);
    vecs[17] = mk(8'h1C, 1'b0, 1'b1, 8'h1C, 1, 0, 0, 1'b1, 1'b0, 1'b0, 2'b10, 3'b100);
    vecs[18] = mk(8'h23, 1'b0, 1'b1, 8'h23, 1, 0, 0, 1'b1, 1'b1, 1'b0, 2'b01, 3'b001);
    vecs[19] = mk(8'h1C, 1'b0, 1'b1, 8'h1C, 1, 0, 0, 1'b1, 1'b1, 1'b0, 2'b01, 3'b100);
    vecs[20] = mk(8'hF0, 1'b0, 1'b1, 8'hF0, 1, 0, 0, 1'b1, 1'b1, 1'b0, 2'b01, 3'b100);
    vecs[21] = mk(8'h23, 1'b0, 1'b1, 8'h23, 1, 0, 0, 1'b1, 1'b0, 1'b0, 2'b10, 3'b100);
    vecs[22] = mk(8'hF0, 1'b0, 1'b1, 8'hF0, 1, 0, 0, 1'b1, 1'b0, 1'b0, 2'b10, 3'b100);
    vecs[23] = mk(8'h1C, 1'b0, 1'b1, 8'h1C, 1, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b100);
    vecs[24] = mk(8'h15, 1'b0, 1'b1, 8'h15, 1, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);

    // Reset state
    rst_n   = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (5) @(negedge clk);
    chk_keys("reset", 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 8'h00);
    chk("reset_code_valid", 32'(code_valid), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_start_pulse", 32'(start_pulse), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < NV; i++) begin
      b_cv = n_cv; b_fe = n_fe; b_sp = n_sp;
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop);
      chk($sformatf("v%0d_cv_count", i), 32'(n_cv - b_cv), 32'(vecs[i].e_cv));
      chk($sformatf("v%0d_fe_count", i), 32'(n_fe - b_fe), 32'(vecs[i].e_fe));
      chk($sformatf("v%0d_sp_count", i), 32'(n_sp - b_sp), 32'(vecs[i].e_sp));
      chk_keys($sformatf("v%0d", i), vecs[i].e_a, vecs[i].e_d, vecs[i].e_en,
               vecs[i].e_mv, vecs[i].e_sig, vecs[i].e_code);
    end

    // Timeout: clock stops after start bit + 3 data bits of 0x23
    b_cv = n_cv; b_fe = n_fe;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_dat = 1'b1;
    repeat (TIMEOUT_CYC - 80) @(negedge clk);
    chk("timeout_not_early", 32'(n_fe - b_fe), 32'd0);
    waited = 0;
    while ((n_fe - b_fe) == 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("timeout_frame_err", 32'(n_fe - b_fe), 32'd1);
    chk("timeout_no_code_valid", 32'(n_cv - b_cv), 32'd0);
    b_cv = n_cv;
    send_frame(8'h23, 1'b0, 1'b1);
    chk("after_timeout_cv", 32'(n_cv - b_cv), 32'd1);
    chk_keys("after_timeout", 1'b0, 1'b1, 1'b0, 2'b01, 3'b001, 8'h23);

    // Short clock glitch with data low must not start a frame
    b_cv = n_cv; b_fe = n_fe;
    @(negedge clk);
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (3) @(negedge clk);
    ps2_dat = 1'b1;
    repeat (TIMEOUT_CYC + 50) @(negedge clk);
    chk("glitch_no_fe", 32'(n_fe - b_fe), 32'd0);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h23, 1'b0, 1'b1);
    chk("glitch_then_frames_cv", 32'(n_cv - b_cv), 32'd2);
    chk_keys("glitch_then_break", 1'b0, 1'b0, 1'b0, 2'b00, 3'b001, 8'h23);

    // Reset in the middle of a frame while A is held
    send_frame(8'h1C, 1'b0, 1'b1);
    chk_keys("pre_reset", 1'b1, 1'b0, 1'b0, 2'b10, 3'b100, 8'h1C);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk_keys("mid_reset", 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 8'h00);
    ps2_dat = 1'b1;
    rst_n   = 1'b1;
    b_cv = n_cv; b_fe = n_fe;
    repeat (TIMEOUT_CYC + 100) @(negedge clk);
    chk("post_reset_no_cv", 32'(n_cv - b_cv), 32'd0);
    chk("post_reset_no_fe", 32'(n_fe - b_fe), 32'd0);
    send_frame(8'h23, 1'b0, 1'b1);
    chk("post_reset_cv", 32'(n_cv - b_cv), 32'd1);
    chk_keys("post_reset", 1'b0, 1'b1, 1'b0, 2'b01, 3'b001, 8'h23);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
